vram_rgb_multi: RTL and testbench

Parametrised, writable multi-channel video RAM that replaces the per-colour read-only 1-bit VRAMs. It holds CHANNELS colour planes of BPC bits each, one word per pixel, in inferred block RAM. The VGA scan-out logic reads it through a 1-cycle-latency read port. The drawing logic writes it through a valid/ready port with per-channel write masks. A built-in clear engine fills the whole frame with one colour.

---
 rtl/vram_rgb_multi.sv | 156 +++++++++++++++
 tb/tb_vram_rgb_multi.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rgb_multi.sv
// Multi-channel video RAM: CHANNELS colour planes of BPC bits per pixel.
// One registered read port for scan-out, one masked valid/ready write port for
// drawing, and a clear engine that fills every valid pixel with one colour.
module vram_rgb_multi #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DEPTH      = 12288,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned BPC        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  // Scan-out read port
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_address,
  output logic [CHANNELS*BPC-1:0]    rd_data,
  output logic                       rd_valid,
  // Drawing write port
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_WIDTH-1:0]      wr_address,
  input  logic [CHANNELS*BPC-1:0]    wr_data,
  input  logic [CHANNELS-1:0]        wr_mask,
  // Clear engine
  input  logic                       clear_start,
  input  logic [CHANNELS*BPC-1:0]    clear_colour,
  output logic                       clear_busy,
  output logic                       clear_done
);

  localparam int unsigned WordW = CHANNELS * BPC;
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } state_e;

  logic [WordW-1:0] mem [DEPTH];

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WordW-1:0]        colour_q, colour_d;
  logic                    wr_ready_q;

  // Internal memory write port, shared by the drawing port and the clear engine
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [WordW-1:0]        mem_wdata;
  logic [CHANNELS-1:0]     mem_wmask;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic [IdxW-1:0]         mem_widx;
  logic [IdxW-1:0]         rd_idx;

  assign rd_in_range = {1'b0, rd_address} < DepthW;
  assign wr_in_range = {1'b0, mem_waddr} < DepthW;
  assign rd_idx      = rd_address[IdxW-1:0];
  assign mem_widx    = mem_waddr[IdxW-1:0];

  // Clear FSM next-state: latch colour on start, sweep counter 0..DEPTH-1
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    colour_d = colour_q;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d  = StClear;
          cnt_d    = '0;
          colour_d = clear_colour;
        end
      end
      StClear: begin
        if (cnt_q == LastAddr) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clear FSM state and registered write-ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      colour_q   <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      colour_q   <= colour_d;
      wr_ready_q <= (state_d == StIdle);
    end
  end

  // Write-port arbitration: the clear engine owns the port while sweeping;
  // drawing writes are only possible while wr_ready is high (IDLE).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_address;
    mem_wdata = wr_data;
    mem_wmask = wr_mask;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = colour_q;
      mem_wmask = '1;
    end else if (wr_valid && wr_ready_q) begin
      mem_we = 1'b1;
    end
    // Reset aborts any write in flight; out-of-range writes are dropped.
    if (reset || !wr_in_range) begin
      mem_we = 1'b0;
    end
  end

  // Memory array: per-channel masked write, contents untouched by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (mem_wmask[i]) begin
          mem[mem_widx][i*BPC +: BPC] <= mem_wdata[i*BPC +: BPC];
        end
      end
    end
  end

  // Read port: one-cycle latency, read-first against a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_in_range ? mem[rd_idx] : '0;
      end
    end
  end

  assign wr_ready   = wr_ready_q;
  assign clear_busy = (state_q == StClear);
  assign clear_done = (state_q == StDone);

endmodule

// File: tb/tb_vram_rgb_multi.sv
// Self-checking bench for vram_rgb_multi: directed vector table, hand-written
// clear/collision/reset sequences, and a randomized phase against an array model.
module tb_vram_rgb_multi;

  localparam int AW    = 14;
  localparam int DEPTH = 12288;
  localparam int CH    = 3;
  localparam int BPC   = 1;
  localparam int W     = CH * BPC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_address = '0;
  logic [W-1:0]  wr_data = '0;
  logic [CH-1:0] wr_mask = '0;
  logic          clear_start = 1'b0;
  logic [W-1:0]  clear_colour = '0;
  logic          clear_busy;
  logic          clear_done;

  vram_rgb_multi #(
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .CHANNELS  (CH),
    .BPC       (BPC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .rd_address  (rd_address),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .clear_start (clear_start),
    .clear_colour(clear_colour),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  always #5 clk = ~clk;

  // Reference picture: one word per pixel
  logic [W-1:0] model [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit           wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [CH-1:0] mask;
    logic [W-1:0]  exp;
    string         name;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(bit wr, int a, logic [W-1:0] d, logic [CH-1:0] m,
                              logic [W-1:0] e, string n);
    vec_t v;
    v.wr   = wr;
    v.addr = AW'(a);
    v.data = d;
    v.mask = m;
    v.exp  = e;
    v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                             input logic [CH-1:0] m);
    if (int'(a) < DEPTH) begin
      for (int i = 0; i < CH; i++) begin
        if (m[i]) model[a][i*BPC +: BPC] = d[i*BPC +: BPC];
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [CH-1:0] m);
    wr_valid   = 1'b1;
    wr_address = a;
    wr_data    = d;
    wr_mask    = m;
    model_write(a, d, m);
    tick();
    wr_valid = 1'b0;
    wr_mask  = '0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [W-1:0] d, output logic v);
    rd_en      = 1'b1;
    rd_address = a;
    tick();
    rd_en = 1'b0;
    d     = rd_data;
    v     = rd_valid;
  endtask

  // Pulse clear_start, then run until clear_done is seen (bounded).
  // restart_at > 0 issues a second clear_start after that many busy cycles.
  task automatic run_clear(input logic [W-1:0] colour, input int restart_at,
                           output int busy_cnt, output int done_cnt, output int rdy_cnt);
    int cyc;
    busy_cnt     = 0;
    done_cnt     = 0;
    rdy_cnt      = 0;
    cyc          = 0;
    clear_start  = 1'b1;
    clear_colour = colour;
    tick();
    clear_start  = 1'b0;
    clear_colour = ~colour;
    while (cyc < 20000 && done_cnt == 0) begin
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
      if (wr_ready) rdy_cnt++;
      clear_start = (restart_at > 0 && busy_cnt == restart_at);
      tick();
      cyc++;
    end
    clear_start = 1'b0;
  endtask

  logic [W-1:0] d;
  logic         v;
  int           busy_cnt, done_cnt, rdy_cnt;

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset wr_ready", wr_ready, 0);
    chk("reset clear_busy", clear_busy, 0);
    chk("reset clear_done", clear_done, 0);
    reset = 1'b0;
    tick();
    chk("wr_ready after reset", wr_ready, 1);
    chk("clear_busy after reset", clear_busy, 0);

    // Directed vectors
    tbl[0]  = mk(1, 5,     3'b101, 3'b111, 3'b000, "w5");
    tbl[1]  = mk(0, 5,     3'b000, 3'b000, 3'b101, "rd5");
    tbl[2]  = mk(1, 100,   3'b111, 3'b111, 3'b000, "w100 init");
    tbl[3]  = mk(1, 100,   3'b000, 3'b010, 3'b000, "w100 mask010");
    tbl[4]  = mk(0, 100,   3'b000, 3'b000, 3'b101, "rd100 masked");
    tbl[5]  = mk(1, 100,   3'b010, 3'b000, 3'b000, "w100 mask000");
    tbl[6]  = mk(0, 100,   3'b000, 3'b000, 3'b101, "rd100 nomask");
    tbl[7]  = mk(1, 7,     3'b001, 3'b111, 3'b000, "w7");
    tbl[8]  = mk(1, 12288, 3'b111, 3'b111, 3'b000, "w oor");
    tbl[9]  = mk(0, 12300, 3'b000, 3'b000, 3'b000, "rd oor");
    tbl[10] = mk(0, 5,     3'b000, 3'b000, 3'b101, "rd5 after oor");
    tbl[11] = mk(0, 7,     3'b000, 3'b000, 3'b001, "rd7 after oor");
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) begin
        chk({tbl[i].name, " wr_ready"}, wr_ready, 1);
        do_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
      end else begin
        do_read(tbl[i].addr, d, v);
        chk({tbl[i].name, " valid"}, v, 1);
        chk(tbl[i].name, d, tbl[i].exp);
      end
    end

    // rd_en low: valid drops, data holds
    tick();
    chk("idle rd_valid", rd_valid, 0);
    chk("idle rd_data hold", rd_data, 3'b001);

    // Read/write collision on addr 7 is read-first
    rd_en      = 1'b1;
    rd_address = 14'd7;
    wr_valid   = 1'b1;
    wr_address = 14'd7;
    wr_data    = 3'b110;
    wr_mask    = 3'b111;
    model_write(14'd7, 3'b110, 3'b111);
    tick();
    rd_en    = 1'b0;
    wr_valid = 1'b0;
    chk("collision old data", rd_data, 3'b001);
    do_read(14'd7, d, v);
    chk("collision new data", d, 3'b110);

    // Full clear with a mid-clear restart attempt
    run_clear(3'b010, 500, busy_cnt, done_cnt, rdy_cnt);
    chk("clear busy cycles", busy_cnt, DEPTH);
    chk("clear done seen", done_cnt, 1);
    chk("wr_ready low during clear", rdy_cnt, 0);
    chk("clear_done one pulse", clear_done, 0);
    chk("wr_ready back", wr_ready, 1);
    chk("clear_busy idle", clear_busy, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 3'b010;
    begin
      int addrs[3];
      addrs = '{0, 6143, 12287};
      foreach (addrs[k]) begin
        do_read(AW'(addrs[k]), d, v);
        chk($sformatf("cleared addr %0d", addrs[k]), d, 3'b010);
      end
    end

    // Randomized mix of reads and writes, collisions included
    begin
      logic [W-1:0]  last;
      logic [W-1:0]  exp_d;
      logic          exp_v;
      logic [AW-1:0] ra, wa;
      logic          re, we;
      last = 3'b010;
      for (int k = 0; k < 400; k++) begin
        re = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        we = 1'($urandom_range(0, 1));
        ra = ($urandom_range(0, 9) == 0) ? AW'(DEPTH + $urandom_range(0, (1 << AW) - DEPTH - 1))
                                         : AW'($urandom_range(0, 15));
        wa = ($urandom_range(0, 9) == 0) ? AW'(DEPTH + $urandom_range(0, (1 << AW) - DEPTH - 1))
                                         : AW'($urandom_range(0, 15));
        if (re) begin
          exp_d = (int'(ra) < DEPTH) ? model[ra] : '0;
          exp_v = 1'b1;
          last  = exp_d;
        end else begin
          exp_d = last;
          exp_v = 1'b0;
        end
        rd_en      = re;
        rd_address = ra;
        wr_valid   = we;
        wr_address = wa;
        wr_data    = W'($urandom);
        wr_mask    = CH'($urandom);
        if (we) model_write(wa, wr_data, wr_mask);
        tick();
        chk($sformatf("rand %0d rd_valid", k), rd_valid, exp_v);
        chk($sformatf("rand %0d rd_data", k), rd_data, exp_d);
      end
      rd_en    = 1'b0;
      wr_valid = 1'b0;
    end

    // Write and clear_start in the same cycle: the clear wins
    wr_valid   = 1'b1;
    wr_address = 14'd0;
    wr_data    = 3'b111;
    wr_mask    = 3'b111;
    run_clear(3'b000, 0, busy_cnt, done_cnt, rdy_cnt);
    wr_valid = 1'b0;
    chk("simul clear done seen", done_cnt, 1);
    chk("simul busy cycles", busy_cnt, DEPTH);
    do_read(14'd0, d, v);
    chk("simul addr0", d, 3'b000);
    do_read(14'd9, d, v);
    chk("simul addr9", d, 3'b000);

    // Reset in the middle of a clear
    do_write(14'd5000, 3'b101, 3'b111);
    clear_start  = 1'b1;
    clear_colour = 3'b110;
    tick();
    clear_start = 1'b0;
    busy_cnt    = 0;
    for (int g = 0; g < 1000 && busy_cnt < 100; g++) begin
      if (clear_busy) busy_cnt++;
      tick();
    end
    chk("mid-clear busy count", busy_cnt, 100);
    reset = 1'b1;
    tick();
    chk("abort clear_busy", clear_busy, 0);
    chk("abort clear_done", clear_done, 0);
    chk("abort wr_ready", wr_ready, 0);
    reset = 1'b0;
    tick();
    chk("abort wr_ready after", wr_ready, 1);
    done_cnt = 0;
    for (int g = 0; g < 5; g++) begin
      if (clear_done || clear_busy) done_cnt++;
      tick();
    end
    chk("no done after abort", done_cnt, 0);
    do_read(14'd50, d, v);
    chk("abort addr50 cleared", d, 3'b110);
    do_read(14'd5000, d, v);
    chk("abort addr5000 kept", d, 3'b101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
